// File: rtl/taxi_xfcp_mod_id_if.sv
// Byte-wide AXI-stream link used between an XFCP switch port and a leaf endpoint.
// master drives data toward the peer; slave consumes it and returns tready.
interface taxi_xfcp_mod_id_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );
endinterface

// File: rtl/taxi_xfcp_mod_id.sv
// XFCP identification leaf: stores the request path, checks the command, and
// answers with the echoed path, terminator, response code, type and ID string.
module taxi_xfcp_mod_id #(
  parameter int            PATH_MAX = 8,
  parameter logic [15:0]   ID_TYPE  = 16'h0001,
  parameter logic [127:0]  ID_STR   = 128'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  taxi_xfcp_mod_id_if.slave         xfcp_in,
  taxi_xfcp_mod_id_if.master        xfcp_out,
  output logic                      stat_drop,
  output logic                      busy
);

  localparam int         AW         = (PATH_MAX > 1) ? $clog2(PATH_MAX) : 1;
  localparam int         DEPTH      = 1 << AW;
  localparam logic [5:0] PATH_MAX_W = 6'(PATH_MAX);
  localparam logic [7:0] BYTE_TERM  = 8'hFE;
  localparam logic [7:0] BYTE_RESP  = 8'h01;
  localparam logic [7:0] CMD_ID     = 8'h00;

  typedef enum logic [1:0] {
    RX_PATH,
    RX_CMD,
    RX_DRAIN,
    TX
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] p_q, p_d;
  logic       overflow_q, overflow_d;
  logic [7:0] cmd_q, cmd_d;
  logic       cmd_seen_q, cmd_seen_d;
  logic [5:0] idx_q, idx_d;
  logic       drop_q, drop_d;

  logic [7:0] path_mem [DEPTH];
  logic       path_we;
  logic       abort;

  logic [7:0] id_byte [16];

  logic       in_ready;
  logic       in_fire;
  logic       out_valid;
  logic       out_fire;
  logic       out_last;
  logic [7:0] out_data;
  logic [5:0] tail_idx;
  logic [3:0] id_idx;
  logic [5:0] last_idx;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_id_byte
      assign id_byte[gi] = ID_STR[8*gi +: 8];
    end
  endgenerate

  // Everything handshake-visible is gated by rst so nothing moves while held in reset.
  assign in_ready  = rst && (state_q != TX);
  assign in_fire   = in_ready && xfcp_in.tvalid;
  assign out_valid = rst && (state_q == TX);
  assign out_fire  = out_valid && xfcp_out.tready;

  // Position within the fixed 20-byte trailer that follows the echoed path.
  assign tail_idx = idx_q - p_q;
  assign id_idx   = tail_idx[3:0] - 4'd4;
  assign last_idx = p_q + 6'd19;
  assign out_last = out_valid && (idx_q == last_idx);

  always_comb begin
    out_data = 8'h00;
    if (idx_q < p_q) begin
      out_data = path_mem[idx_q[AW-1:0]];
    end else begin
      case (tail_idx)
        6'd0:    out_data = BYTE_TERM;
        6'd1:    out_data = BYTE_RESP;
        6'd2:    out_data = ID_TYPE[15:8];
        6'd3:    out_data = ID_TYPE[7:0];
        default: out_data = id_byte[id_idx];
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    overflow_d = overflow_q;
    cmd_d      = cmd_q;
    cmd_seen_d = cmd_seen_q;
    idx_d      = idx_q;
    drop_d     = 1'b0;
    path_we    = 1'b0;
    abort      = 1'b0;

    case (state_q)
      RX_PATH: begin
        if (in_fire) begin
          if (xfcp_in.tdata == BYTE_TERM) begin
            if (xfcp_in.tlast) begin
              abort = 1'b1;
            end else begin
              state_d = RX_CMD;
            end
          end else begin
            // Path bytes past capacity are swallowed; the request is poisoned.
            if (p_q == PATH_MAX_W) begin
              overflow_d = 1'b1;
            end else begin
              path_we = 1'b1;
              p_d     = p_q + 6'd1;
            end
            if (xfcp_in.tlast) begin
              abort = 1'b1;
            end
          end
        end
      end

      RX_CMD: begin
        if (in_fire) begin
          cmd_d      = xfcp_in.tdata;
          cmd_seen_d = 1'b1;
          if (xfcp_in.tlast) begin
            if ((xfcp_in.tdata == CMD_ID) && !xfcp_in.tuser && !overflow_q) begin
              state_d = TX;
              idx_d   = 6'd0;
            end else begin
              abort = 1'b1;
            end
          end else begin
            state_d = RX_DRAIN;
          end
        end
      end

      RX_DRAIN: begin
        if (in_fire && xfcp_in.tlast) begin
          if ((cmd_q == CMD_ID) && cmd_seen_q && !xfcp_in.tuser && !overflow_q) begin
            state_d = TX;
            idx_d   = 6'd0;
          end else begin
            abort = 1'b1;
          end
        end
      end

      TX: begin
        if (out_fire) begin
          if (out_last) begin
            state_d    = RX_PATH;
            p_d        = 6'd0;
            idx_d      = 6'd0;
            cmd_seen_d = 1'b0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end

      default: state_d = RX_PATH;
    endcase

    if (abort) begin
      drop_d     = 1'b1;
      p_d        = 6'd0;
      overflow_d = 1'b0;
      cmd_seen_d = 1'b0;
      state_d    = RX_PATH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RX_PATH;
      p_q        <= 6'd0;
      overflow_q <= 1'b0;
      cmd_q      <= 8'h00;
      cmd_seen_q <= 1'b0;
      idx_q      <= 6'd0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      overflow_q <= overflow_d;
      cmd_q      <= cmd_d;
      cmd_seen_q <= cmd_seen_d;
      idx_q      <= idx_d;
      drop_q     <= drop_d;
    end
  end

  // Path storage carries no reset; P alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (path_we) begin
      path_mem[p_q[AW-1:0]] <= xfcp_in.tdata;
    end
  end

  assign xfcp_in.tready  = in_ready;
  assign xfcp_out.tdata  = out_data;
  assign xfcp_out.tvalid = out_valid;
  assign xfcp_out.tlast  = out_last;
  assign xfcp_out.tuser  = 1'b0;

  assign stat_drop = rst && drop_q;
  assign busy      = rst && ((state_q != RX_PATH) || (p_q != 6'd0) || overflow_q);

endmodule

// File: tb/tb_taxi_xfcp_mod_id.sv
// Randomized bench for the XFCP ID leaf: a request-level model predicts each
// response or drop, and a negedge monitor checks every output beat against it.
module tb_taxi_xfcp_mod_id;
  localparam int             PATH_MAX = 8;
  localparam logic [15:0]    ID_TYPE  = 16'h0001;
  localparam logic [127:0]   ID_STR   = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

  logic clk;
  logic rst;
  logic stat_drop;
  logic busy;

  taxi_xfcp_mod_id_if in_if ();
  taxi_xfcp_mod_id_if out_if ();

  taxi_xfcp_mod_id #(
    .PATH_MAX (PATH_MAX),
    .ID_TYPE  (ID_TYPE),
    .ID_STR   (ID_STR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .xfcp_in   (in_if),
    .xfcp_out  (out_if),
    .stat_drop (stat_drop),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [7:0] req_q[$];
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  logic [7:0] got_q[$];
  int         drop_cnt   = 0;
  int         exp_drops  = 0;
  int         out_acc    = 0;
  bit         expect_resp = 1'b0;
  bit         rand_ready  = 1'b0;
  bit         last_in_seen = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s act=timeout exp=done t=%0t", name, $time);
  endtask

  // Request-level model: find the terminator, validate, build the response.
  function automatic bit model_req(input logic user_last);
    int f;
    f = -1;
    model_q.delete();
    for (int i = 0; i < req_q.size(); i++)
      if (f < 0 && req_q[i] == 8'hFE) f = i;
    if (f < 0) return 1'b0;
    if (f == req_q.size() - 1) return 1'b0;
    if (f > PATH_MAX) return 1'b0;
    if (req_q[f+1] != 8'h00) return 1'b0;
    if (user_last) return 1'b0;
    for (int i = 0; i < f; i++) model_q.push_back(req_q[i]);
    model_q.push_back(8'hFE);
    model_q.push_back(8'h01);
    model_q.push_back(ID_TYPE[15:8]);
    model_q.push_back(ID_TYPE[7:0]);
    for (int k = 0; k < 16; k++) model_q.push_back(ID_STR[8*k +: 8]);
    return 1'b1;
  endfunction

  initial begin
    out_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall   = 1'b0;
      last_in_seen = 1'b0;
    end else begin
      if (last_in_seen) begin
        chk("resp_start", out_if.tvalid, expect_resp);
        chk("drop_pulse", stat_drop, !expect_resp);
        last_in_seen = 1'b0;
      end
      if (out_if.tvalid) begin
        chk("in_ready_in_tx", in_if.tready, 0);
        chk("out_tuser", out_if.tuser, 0);
        chk("busy_in_tx", busy, 1);
      end
      if (prev_stall) begin
        chk("stall_valid", out_if.tvalid, 1);
        chk("stall_data", out_if.tdata, prev_data);
        chk("stall_last", out_if.tlast, prev_last);
      end
      if (stat_drop) drop_cnt++;
      if (out_if.tvalid && out_if.tready) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_byte");
        end else begin
          chk("out_data", out_if.tdata, exp_q.pop_front());
          chk("out_last", out_if.tlast, exp_last_q.pop_front());
        end
        got_q.push_back(out_if.tdata);
        out_acc++;
      end
      prev_stall = out_if.tvalid && !out_if.tready;
      prev_data  = out_if.tdata;
      prev_last  = out_if.tlast;
      if (in_if.tvalid && in_if.tready && in_if.tlast) last_in_seen = 1'b1;
    end
  end

  // Caller is always at posedge+1; returns at posedge+1.
  task automatic send_req(input logic user_last);
    bit acc;
    for (int i = 0; i < req_q.size(); i++) begin
      while ($urandom_range(0, 9) < 3) begin
        in_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_if.tvalid = 1'b1;
      in_if.tdata  = req_q[i];
      in_if.tlast  = (i == req_q.size() - 1);
      in_if.tuser  = (i == req_q.size() - 1) ? user_last : 1'b0;
      acc = 1'b0;
      for (int c = 0; c < 1000 && !acc; c++) begin
        @(negedge clk);
        acc = in_if.tready && rst;
        @(posedge clk);
        #1;
      end
      if (!acc) timeout("send_beat");
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = 1'b0;
  endtask

  task automatic prime(input logic user_last, output bit ok);
    got_q.delete();
    ok = model_req(user_last);
    expect_resp = ok;
    if (ok) begin
      for (int i = 0; i < model_q.size(); i++) begin
        exp_q.push_back(model_q[i]);
        exp_last_q.push_back(i == model_q.size() - 1);
      end
    end else begin
      exp_drops++;
    end
  endtask

  task automatic run_req(input logic user_last);
    bit ok;
    bit done;
    prime(user_last, ok);
    send_req(user_last);
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy;
    end
    @(posedge clk);
    #1;
    if (!done) timeout("req_complete");
    chk("drop_count", drop_cnt, exp_drops);
    chk("exp_left", exp_q.size(), 0);
    if (ok) chk("resp_len", got_q.size(), model_q.size());
    $display("req in_len=%0d valid=%0d resp_len=%0d drops=%0d", req_q.size(), ok, got_q.size(), drop_cnt);
  endtask

  task automatic gen_random(output logic user_last);
    int plen;
    int kind;
    int extra;
    req_q.delete();
    plen = $urandom_range(0, 10);
    for (int i = 0; i < plen; i++) req_q.push_back(8'($urandom_range(0, 253)));
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      if (plen == 0) req_q.push_back(8'($urandom_range(0, 253)));
    end else begin
      req_q.push_back(8'hFE);
      if (kind != 1) begin
        req_q.push_back((kind == 2) ? 8'($urandom_range(1, 255)) : 8'h00);
        extra = $urandom_range(0, 3);
        for (int i = 0; i < extra; i++) req_q.push_back(8'($urandom_range(0, 255)));
      end
    end
    user_last = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    logic ul;
    bit ok;
    bit hit;
    int base;

    rst = 1'b0;
    in_if.tvalid = 1'b0;
    in_if.tdata  = 8'h00;
    in_if.tlast  = 1'b0;
    in_if.tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_if.tready, 0);
    chk("rst_out_valid", out_if.tvalid, 0);
    chk("rst_out_last", out_if.tlast, 0);
    chk("rst_out_user", out_if.tuser, 0);
    chk("rst_drop", stat_drop, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_if.tready, 1);
    @(posedge clk);
    #1;

    // Direct ID request, always-ready sink.
    req_q = '{8'hFE, 8'h00};
    run_req(1'b0);
    chk("direct_len", got_q.size(), 20);
    chk("direct_b0", got_q[0], 8'hFE);
    chk("direct_b1", got_q[1], 8'h01);
    chk("direct_b2", got_q[2], 8'h00);
    chk("direct_b3", got_q[3], 8'h01);
    chk("direct_b4", got_q[4], 8'h0F);
    chk("direct_b19", got_q[19], 8'hF0);

    rand_ready = 1'b1;

    // Path echo with trailing ignored bytes.
    req_q = '{8'h02, 8'h05, 8'hFE, 8'h00, 8'hAA, 8'hBB};
    run_req(1'b0);
    chk("echo_model_len", model_q.size(), 22);
    chk("echo_len", got_q.size(), 22);
    chk("echo_b0", got_q[0], 8'h02);
    chk("echo_b1", got_q[1], 8'h05);
    chk("echo_b2", got_q[2], 8'hFE);
    chk("echo_b3", got_q[3], 8'h01);
    chk("echo_b4", got_q[4], 8'h00);
    chk("echo_b5", got_q[5], 8'h01);

    // Drop cases, each followed by a normal request.
    base = drop_cnt;
    req_q = '{8'hFE, 8'h03};
    run_req(1'b0);
    req_q = '{8'hFE, 8'h00};
    run_req(1'b0);
    req_q = '{8'hFE, 8'h00};
    run_req(1'b1);
    req_q = '{8'hFE, 8'h00};
    run_req(1'b0);
    req_q = '{8'h01};
    run_req(1'b0);
    req_q = '{8'hFE, 8'h00};
    run_req(1'b0);
    chk("drop_cases", drop_cnt - base, 3);

    // Overflow at PATH_MAX+1 path bytes, and the exact-fit boundary.
    req_q.delete();
    for (int i = 0; i < PATH_MAX + 1; i++) req_q.push_back(8'(i + 16));
    req_q.push_back(8'hFE);
    req_q.push_back(8'h00);
    run_req(1'b0);
    chk("overflow_drop", drop_cnt - base, 4);
    req_q.delete();
    for (int i = 0; i < PATH_MAX; i++) req_q.push_back(8'(i + 32));
    req_q.push_back(8'hFE);
    req_q.push_back(8'h00);
    run_req(1'b0);
    chk("full_path_len", got_q.size(), PATH_MAX + 20);
    chk("full_path_b7", got_q[PATH_MAX-1], 8'(PATH_MAX + 31));

    for (int n = 0; n < 40; n++) begin
      gen_random(ul);
      run_req(ul);
    end

    // Reset in the middle of a response.
    req_q = '{8'h07, 8'hFE, 8'h00};
    prime(1'b0, ok);
    base = out_acc;
    send_req(1'b0);
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      if (out_acc - base >= 5) hit = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!hit) timeout("five_bytes");
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", out_if.tvalid, 0);
    chk("mid_rst_ready", in_if.tready, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_last_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("rel_rst_ready", in_if.tready, 1);
    chk("rel_rst_valid", out_if.tvalid, 0);
    chk("rel_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    req_q = '{8'hFE, 8'h00};
    run_req(1'b0);
    chk("fresh_len", got_q.size(), 20);
    chk("fresh_b0", got_q[0], 8'hFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
